// File: rtl/uart_tx_if.sv
// Write port and status bundle between data_memory and the UART transmitter.
// data_memory (master) strobes bytes in and reads back the status flags.
// The serial pin is not part of this bundle; it goes straight to the board.
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          wr_en;
    logic [7:0]                    wr_data;
    logic                          full;
    logic                          busy;
    logic                          overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output wr_en,
        output wr_data,
        input  full,
        input  busy,
        input  overflow,
        input  fifo_count
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output full,
        output busy,
        output overflow,
        output fifo_count
    );
endinterface

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Bytes written by data_memory are queued in a small circular FIFO and shifted
// out LSB first. Back-to-back frames are sent with no idle bit between them.
// reset is asynchronous and active-low; asserting it mid-frame aborts the frame,
// drives the line high and discards everything queued.
module uart_tx #(
    parameter int CLKS_PER_BIT = 417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  bus,
    output logic      serial_txd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      shift_reg;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            full_q;
    logic            overflow_q;

    logic            baud_end;
    logic            fifo_empty;
    logic            fifo_at_full;
    logic            push;
    logic            pop;
    logic [7:0]      head_byte;

    // Handshake decode: a pop happens whenever the serialiser is ready for a new
    // byte (idle, or finishing a stop bit) and something is queued. A write is
    // accepted only when the FIFO was not full at this edge, even if a pop frees
    // a slot in the same cycle.
    always_comb begin
        baud_end     = (baud_cnt == BAUD_LAST);
        fifo_empty   = (count == '0);
        fifo_at_full = (count == COUNT_FULL);
        head_byte    = fifo_mem[rd_ptr];
        push         = bus.wr_en && !fifo_at_full;
        pop          = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));
        count_next   = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers and count gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers, occupancy and the status flags returned to data_memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count  <= count_next;
            full_q <= (count_next == COUNT_FULL);
            if (bus.wr_en && fifo_at_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Serialiser: start bit, eight data bits LSB first, stop bit, each held CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            serial_txd <= 1'b1;
            shift_reg  <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    serial_txd <= 1'b1;
                    baud_cnt   <= '0;
                    bit_idx    <= '0;
                    if (pop) begin
                        shift_reg  <= head_byte;
                        serial_txd <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        serial_txd <= shift_reg[0];
                        state      <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx    <= '0;
                            serial_txd <= 1'b1;
                            state      <= STOP;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            shift_reg  <= shift_reg >> 1;
                            serial_txd <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg  <= head_byte;
                            serial_txd <= 1'b0;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_txd <= 1'b1;
                end
            endcase
        end
    end

    assign bus.full       = full_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = count;
    assign bus.busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with a fast baud (4 clocks per bit).
// Accepted bytes are pushed to a scoreboard queue as they are written; a line
// monitor decodes each frame off serial_txd and pops the expected byte.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic serial_txd;

    uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .serial_txd (serial_txd)
    );

    // 10-unit clock period; inputs change 1 unit after each rising edge.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb_q[$];

    bit         in_frame       = 1'b0;
    int         bit_cyc        = 0;
    logic [7:0] rx_byte        = '0;
    int         idle_gap       = 0;
    int         last_gap       = -1;
    int         frames_started = 0;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Line monitor: sampled on the falling edge, decodes one 8N1 frame at a time
    // and records the idle gap that preceded each start bit.
    always @(negedge clk) begin
        if (!reset) begin
            in_frame = 1'b0;
            idle_gap = 0;
        end else if (!in_frame) begin
            if (serial_txd === 1'b0) begin
                in_frame = 1'b1;
                bit_cyc  = 0;
                last_gap = idle_gap;
                frames_started++;
            end else begin
                idle_gap++;
            end
        end else begin
            bit_cyc++;
        end
        if (reset && in_frame) begin
            if (bit_cyc == 2) begin
                check_output("start_bit", serial_txd, 0);
            end
            if (bit_cyc >= 6 && bit_cyc <= 34 && ((bit_cyc - 6) % 4) == 0) begin
                rx_byte[(bit_cyc - 6) / 4] = serial_txd;
            end
            if (bit_cyc == 38) begin
                check_output("stop_bit", serial_txd, 1);
            end
            if (bit_cyc == 39) begin
                in_frame = 1'b0;
                idle_gap = 0;
                if (sb_q.size() == 0) begin
                    check_output("rx_unexpected", 1, 0);
                end else begin
                    check_output("rx_byte", rx_byte, sb_q.pop_front());
                end
            end
        end
    end

    // Drive one write strobe for a single edge; accepted bytes join the scoreboard.
    task automatic write_byte(input logic [7:0] data, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = data;
        if (accept) begin
            sb_q.push_back(data);
        end
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    // Wait (bounded) for the transmitter to drain, tracking the peak FIFO occupancy.
    task automatic wait_idle(input int budget, output int peak);
        int n;
        n    = 0;
        peak = int'(bus.fifo_count);
        while (bus.busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (int'(bus.fifo_count) > peak) begin
                peak = int'(bus.fifo_count);
            end
        end
        check_output("idle_reached", bus.busy, 0);
    endtask

    // Pulse reset across at least one falling edge and clear the scoreboard model.
    task automatic do_reset();
        reset = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int         peak;
        int         frames_before;
        logic [9:0] frame;

        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        reset       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Reset while idle: outputs return to their idle values asynchronously.
        reset = 1'b0;
        #1;
        check_output("rst_txd", serial_txd, 1);
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_full", bus.full, 0);
        check_output("rst_overflow", bus.overflow, 0);
        check_output("rst_count", bus.fifo_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("post_rst_txd", serial_txd, 1);
        check_output("post_rst_busy", bus.busy, 0);

        // Single byte 0xA5: exact per-cycle waveform and busy release at k+41.
        write_byte(8'hA5, 1'b1);
        check_output("a5_count_k", bus.fifo_count, 1);
        check_output("a5_busy_k", bus.busy, 1);
        check_output("a5_txd_k", serial_txd, 1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CPB; j++) begin
                @(posedge clk);
                #1;
                check_output("a5_line", serial_txd, frame[i]);
                if (i == 0 && j == 0) begin
                    check_output("a5_count_k1", bus.fifo_count, 0);
                end
            end
        end
        check_output("a5_busy_k40", bus.busy, 1);
        @(posedge clk);
        #1;
        check_output("a5_busy_k41", bus.busy, 0);
        check_output("a5_txd_idle", serial_txd, 1);
        repeat (3) @(posedge clk);
        #1;

        // Two back-to-back bytes: contiguous frames, occupancy never above 1.
        write_byte(8'h55, 1'b1);
        check_output("b2b_count1", bus.fifo_count, 1);
        write_byte(8'h0F, 1'b1);
        check_output("b2b_count2", bus.fifo_count, 1);
        frames_before = frames_started;
        wait_idle(200, peak);
        check_output("b2b_peak", peak, 1);
        check_output("b2b_frames", frames_started - frames_before, 2);
        check_output("b2b_gap", last_gap, 0);
        check_output("b2b_sb_empty", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;

        // Six writes into a depth-4 FIFO: the sixth is dropped and overflow sticks.
        for (int v = 1; v <= 6; v++) begin
            write_byte(8'(v), v <= 5);
            if (v == 4) begin
                check_output("ovf_full_w4", bus.full, 0);
            end
            if (v == 5) begin
                check_output("ovf_full_w5", bus.full, 1);
                check_output("ovf_count_w5", bus.fifo_count, 4);
                check_output("ovf_flag_w5", bus.overflow, 0);
            end
            if (v == 6) begin
                check_output("ovf_flag_w6", bus.overflow, 1);
                check_output("ovf_count_w6", bus.fifo_count, 4);
            end
        end
        wait_idle(400, peak);
        check_output("ovf_sticky", bus.overflow, 1);
        check_output("ovf_sb_empty", sb_q.size(), 0);
        do_reset();
        check_output("ovf_cleared", bus.overflow, 0);

        // Reset during data bit 3 of 0xA5 with two bytes still queued.
        write_byte(8'hA5, 1'b1);
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        check_output("abort_count", bus.fifo_count, 2);
        repeat (16) @(posedge clk);
        #1;
        check_output("abort_bit3", serial_txd, 0);
        reset = 1'b0;
        #1;
        check_output("abort_txd", serial_txd, 1);
        check_output("abort_count_rst", bus.fifo_count, 0);
        check_output("abort_busy", bus.busy, 0);
        sb_q.delete();
        frames_before = frames_started;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (c % 10 == 0) begin
                check_output("abort_idle_txd", serial_txd, 1);
            end
        end
        check_output("abort_no_frame", frames_started - frames_before, 0);
        check_output("abort_busy_after", bus.busy, 0);

        // Full FIFO during a frame; a write on the STOP->START pop edge is dropped.
        for (int v = 0; v < 5; v++) begin
            write_byte(8'h31 + 8'(v), 1'b1);
        end
        check_output("pop_edge_full", bus.full, 1);
        check_output("pop_edge_count", bus.fifo_count, 4);
        check_output("pop_edge_ovf0", bus.overflow, 0);
        repeat (36) @(posedge clk);
        #1;
        check_output("pop_edge_stop", serial_txd, 1);
        check_output("pop_edge_count_pre", bus.fifo_count, 4);
        write_byte(8'h99, 1'b0);
        check_output("pop_edge_ovf1", bus.overflow, 1);
        check_output("pop_edge_count_post", bus.fifo_count, 3);
        check_output("pop_edge_full_post", bus.full, 0);
        check_output("pop_edge_start", serial_txd, 0);
        wait_idle(400, peak);
        check_output("pop_edge_gap", last_gap, 0);
        check_output("pop_edge_sb_empty", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
